// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller: FSM states,
// register-index type and the per-stage enable/flush patterns.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        TRAP     = 2'd2
    } state_t;

    typedef logic [4:0] reg_idx_t;

    localparam reg_idx_t REG_ZERO = 5'd0;

    typedef struct packed {
        logic pc_en;
        logic ifid_en;
        logic ifid_flush;
        logic idex_en;
        logic idex_flush;
        logic exmem_en;
        logic memwb_en;
        logic memwb_flush;
    } stage_ctrl_t;

    localparam stage_ctrl_t CTRL_RUN = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b0, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

    // Whole pipeline frozen; MEM/WB takes a bubble so a stalled access never writes back twice.
    localparam stage_ctrl_t CTRL_FREEZE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b0, idex_flush: 1'b0, exmem_en: 1'b0, memwb_en: 1'b0, memwb_flush: 1'b1};

    localparam stage_ctrl_t CTRL_RESET = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b1,
        idex_en: 1'b0, idex_flush: 1'b1, exmem_en: 1'b0, memwb_en: 1'b0, memwb_flush: 1'b1};

    localparam stage_ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, ifid_en: 1'b1, ifid_flush: 1'b1,
        idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

    localparam stage_ctrl_t CTRL_LOAD_USE = '{pc_en: 1'b0, ifid_en: 1'b0, ifid_flush: 1'b0,
        idex_en: 1'b1, idex_flush: 1'b1, exmem_en: 1'b1, memwb_en: 1'b1, memwb_flush: 1'b0};

    // A load writing r0 never creates a dependency, since r0 reads as zero.
    function automatic logic load_use_hazard(input logic memread, input reg_idx_t ex_rt,
                                             input reg_idx_t rs, input reg_idx_t rt,
                                             input logic uses_rt);
        return memread && (ex_rt != REG_ZERO) &&
               ((ex_rt == rs) || (uses_rt && (ex_rt == rt)));
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Hazard sources from the datapath and per-stage load/flush controls returned to it.
// master = the hazard controller, slave = the datapath.
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_idx_t id_rs;
    reg_idx_t id_rt;
    logic     id_uses_rt;
    logic     idex_memread;
    reg_idx_t idex_rt;
    logic     ex_branch_taken;
    logic     exmem_memread;
    logic     exmem_memwrite;
    logic     mem_ready;

    logic pc_en;
    logic ifid_en;
    logic ifid_flush;
    logic idex_en;
    logic idex_flush;
    logic exmem_en;
    logic memwb_en;
    logic memwb_flush;
    logic mem_timeout;

    modport master (
        input  id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken,
               exmem_memread, exmem_memwrite, mem_ready,
        output pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, memwb_flush, mem_timeout
    );

    modport slave (
        output id_rs, id_rt, id_uses_rt, idex_memread, idex_rt, ex_branch_taken,
               exmem_memread, exmem_memwrite, mem_ready,
        input  pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
               memwb_en, memwb_flush, mem_timeout
    );

endinterface

// File: rtl/mem_wait_timer.sv
// Counts cycles spent waiting on data memory; saturates at MEM_TIMEOUT and flags expiry.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic clock,
    input  logic reset_n,
    input  logic start,
    input  logic inc,
    output logic expired
);

    localparam int W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [W-1:0] LIMIT = W'(MEM_TIMEOUT);

    logic [W-1:0] wait_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            wait_cnt <= '0;
        end else if (start) begin
            wait_cnt <= W'(1);
        end else if (inc && (wait_cnt != LIMIT)) begin
            wait_cnt <= wait_cnt + W'(1);
        end
    end

    assign expired = (wait_cnt == LIMIT);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard controller: per-stage enable/flush from load-use, branch and memory stalls,
// with a memory watchdog trap. Define HAZ_PERF_CNT_EN to add stall/flush performance counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 15
`ifdef HAZ_PERF_CNT_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                    clock,
    input  logic                    reset_n,
    pipeline_hazard_ctrl_if.master  hz
`ifdef HAZ_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]        stall_cycles,
    output logic [CNT_W-1:0]        flush_events
`endif
);

    state_t      state, next_state;
    stage_ctrl_t ctrl;
    logic        mem_timeout_q;
    logic        mem_stall, hazard, expired, timer_start, timer_inc;

    assign mem_stall = (hz.exmem_memread | hz.exmem_memwrite) & ~hz.mem_ready;
    assign hazard    = load_use_hazard(hz.idex_memread, hz.idex_rt, hz.id_rs, hz.id_rt,
                                       hz.id_uses_rt);

    mem_wait_timer #(.MEM_TIMEOUT(MEM_TIMEOUT)) u_timer (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (timer_start),
        .inc     (timer_inc),
        .expired (expired)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state         <= RUN;
            mem_timeout_q <= 1'b0;
        end else begin
            state         <= next_state;
            mem_timeout_q <= mem_timeout_q | (next_state == TRAP);
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        next_state  = state;
        ctrl        = CTRL_RUN;
        timer_start = 1'b0;
        timer_inc   = 1'b0;
        unique case (state)
            RUN: begin
                if (mem_stall) begin
                    ctrl        = CTRL_FREEZE;
                    next_state  = MEM_WAIT;
                    timer_start = 1'b1;
                end else if (hz.ex_branch_taken) begin
                    ctrl = CTRL_BRANCH;
                end else if (hazard) begin
                    ctrl = CTRL_LOAD_USE;
                end
            end
            MEM_WAIT: begin
                if (hz.mem_ready) begin
                    next_state = RUN;
                end else begin
                    ctrl = CTRL_FREEZE;
                    if (expired) next_state = TRAP;
                    else         timer_inc  = 1'b1;
                end
            end
            TRAP:    ctrl = CTRL_FREEZE;
            default: next_state = RUN;
        endcase
        // Reset overrides everything so the datapath fills with bubbles while held.
        if (!reset_n) ctrl = CTRL_RESET;
    end

    assign hz.pc_en       = ctrl.pc_en;
    assign hz.ifid_en     = ctrl.ifid_en;
    assign hz.ifid_flush  = ctrl.ifid_flush;
    assign hz.idex_en     = ctrl.idex_en;
    assign hz.idex_flush  = ctrl.idex_flush;
    assign hz.exmem_en    = ctrl.exmem_en;
    assign hz.memwb_en    = ctrl.memwb_en;
    assign hz.memwb_flush = ctrl.memwb_flush;
    assign hz.mem_timeout = mem_timeout_q;

`ifdef HAZ_PERF_CNT_EN
    logic stall_evt, flush_evt;

    assign stall_evt = reset_n && !ctrl.pc_en && (state != TRAP);
    assign flush_evt = (ctrl == CTRL_BRANCH);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_events <= '0;
        end else begin
            if (stall_evt && (stall_cycles != '1)) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_evt && (flush_events != '1)) flush_events <= flush_events + CNT_W'(1);
        end
    end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: expected controls are queued when stimulus is
// applied and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

    // Bit order: pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_en, memwb_flush
    localparam logic [7:0] C_RUN    = 8'b1101_0110;
    localparam logic [7:0] C_FREEZE = 8'b0000_0001;
    localparam logic [7:0] C_RESET  = 8'b0010_1001;
    localparam logic [7:0] C_BRANCH = 8'b1111_1110;
    localparam logic [7:0] C_LU     = 8'b0001_1110;

    logic clock = 1'b0;
    logic reset_n;

    int tests = 0;
    int fails = 0;

    logic [8:0] exp_q[$];
    string      tag_q[$];

    pipeline_hazard_ctrl_if hz ();

`ifdef HAZ_PERF_CNT_EN
    logic [31:0] stall_cycles, flush_events;
    int m_stall = 0;
    int m_flush = 0;

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15), .CNT_W(32)) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .hz           (hz),
        .stall_cycles (stall_cycles),
        .flush_events (flush_events)
    );
`else
    pipeline_hazard_ctrl #(.MEM_TIMEOUT(15)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .hz      (hz)
    );
`endif

    always #5 clock = ~clock;

    task automatic idle();
        hz.id_rs = 5'd0; hz.id_rt = 5'd0; hz.id_uses_rt = 1'b0;
        hz.idex_memread = 1'b0; hz.idex_rt = 5'd0; hz.ex_branch_taken = 1'b0;
        hz.exmem_memread = 1'b0; hz.exmem_memwrite = 1'b0; hz.mem_ready = 1'b0;
    endtask

    task automatic check_out();
        logic [8:0] obs, exp;
        string      tag;
        obs = {hz.mem_timeout, hz.pc_en, hz.ifid_en, hz.ifid_flush, hz.idex_en, hz.idex_flush,
               hz.exmem_en, hz.memwb_en, hz.memwb_flush};
        tests++;
        if (exp_q.size() == 0) begin
            fails++;
            $error("FAIL scoreboard_empty: observed %b, no expected entry", obs);
        end else begin
            exp = exp_q.pop_front();
            tag = tag_q.pop_front();
            assert (obs === exp) else begin
                fails++;
                $error("FAIL %s: observed timeout/ctrl %b expected %b", tag, obs, exp);
            end
        end
    endtask

    // Apply current inputs for one cycle: queue expectation, compare mid-cycle, advance.
    task automatic step(input string tag, input logic [7:0] exp_ctrl, input logic exp_to);
        exp_q.push_back({exp_to, exp_ctrl});
        tag_q.push_back(tag);
        @(negedge clock);
        check_out();
`ifdef HAZ_PERF_CNT_EN
        if (!reset_n) begin
            m_stall = 0;
            m_flush = 0;
        end else begin
            if (!exp_ctrl[7] && !exp_to) m_stall++;
            if (exp_ctrl == C_BRANCH)    m_flush++;
        end
`endif
        @(posedge clock);
        #1;
    endtask

`ifdef HAZ_PERF_CNT_EN
    task automatic check_cnt(input string tag);
        tests++;
        assert (stall_cycles === 32'(m_stall)) else begin
            fails++;
            $error("FAIL %s_stall: observed %0d expected %0d", tag, stall_cycles, m_stall);
        end
        tests++;
        assert (flush_events === 32'(m_flush)) else begin
            fails++;
            $error("FAIL %s_flush: observed %0d expected %0d", tag, flush_events, m_flush);
        end
    endtask
`endif

    initial begin
        idle();
        reset_n = 1'b0;
        step("reset_0", C_RESET, 1'b0);
        step("reset_1", C_RESET, 1'b0);
        reset_n = 1'b1;
        step("idle", C_RUN, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_cnt("cnt_reset");
`endif

        // Load-use through rs: one bubble, then the stall clears.
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd8; hz.id_rs = 5'd8;
        step("lu_rs", C_LU, 1'b0);
        idle();
        step("lu_clear", C_RUN, 1'b0);

        // r0 destination never stalls; rt match only counts when rt is a source.
        hz.idex_memread = 1'b1; hz.idex_rt = 5'd0; hz.id_rs = 5'd0; hz.id_rt = 5'd0;
        hz.id_uses_rt = 1'b1;
        step("zero_reg", C_RUN, 1'b0);
        hz.idex_rt = 5'd9; hz.id_rs = 5'd3; hz.id_rt = 5'd9; hz.id_uses_rt = 1'b0;
        step("rt_unused", C_RUN, 1'b0);
        hz.id_uses_rt = 1'b1;
        step("lu_rt", C_LU, 1'b0);
        idle();

        // Taken branch wins over a coincident load-use.
        hz.ex_branch_taken = 1'b1; hz.idex_memread = 1'b1; hz.idex_rt = 5'd8; hz.id_rs = 5'd8;
        step("br_lu", C_BRANCH, 1'b0);
        idle();
        step("br_after", C_RUN, 1'b0);

        // Store stalled three cycles; the memory stall also masks a taken branch.
        hz.exmem_memwrite = 1'b1; hz.mem_ready = 1'b0; hz.ex_branch_taken = 1'b1;
        step("st_wait1", C_FREEZE, 1'b0);
        hz.ex_branch_taken = 1'b0;
        step("st_wait2", C_FREEZE, 1'b0);
        step("st_wait3", C_FREEZE, 1'b0);
        hz.mem_ready = 1'b1;
        step("st_done", C_RUN, 1'b0);
        idle();
        step("st_after", C_RUN, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_cnt("cnt_mid");
`endif

        // Hung load: entry cycle plus 15 wait cycles, then a sticky trap.
        hz.exmem_memread = 1'b1; hz.mem_ready = 1'b0;
        step("to_enter", C_FREEZE, 1'b0);
        for (int i = 1; i <= 15; i++) step($sformatf("to_wait%0d", i), C_FREEZE, 1'b0);
        step("trap_0", C_FREEZE, 1'b1);
        hz.mem_ready = 1'b1;
        step("trap_sticky_1", C_FREEZE, 1'b1);
        step("trap_sticky_2", C_FREEZE, 1'b1);
        reset_n = 1'b0;
        step("trap_reset", C_RESET, 1'b1);
        reset_n = 1'b1;
        step("trap_cleared", C_RUN, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_cnt("cnt_after_trap_reset");
`endif
        idle();

        // Ready arrives exactly when the wait count reaches the limit: no trap.
        hz.exmem_memread = 1'b1; hz.mem_ready = 1'b0;
        step("edge_enter", C_FREEZE, 1'b0);
        for (int i = 1; i <= 14; i++) step($sformatf("edge_wait%0d", i), C_FREEZE, 1'b0);
        hz.mem_ready = 1'b1;
        step("edge_ready", C_RUN, 1'b0);
        idle();
        step("edge_after", C_RUN, 1'b0);
`ifdef HAZ_PERF_CNT_EN
        check_cnt("cnt_final");
`endif

        tests++;
        assert (exp_q.size() == 0) else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d left expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
